editor_input_scheduler: RTL and testbench

Front-end sequencer for the sentence editor. Parses the raw PS/2 scan-byte stream into make codes, turns debounced push-button levels into single-cycle commands, and arbitrates both sources. The editor receives at most one command per clock, with a fixed priority. It sits between the keyboard receiver / debouncers and the editor's `keyboard`, `prevWord`, `nextWord`, `save` and `load` inputs.

---
 rtl/editor_pkg.sv | 31 +++
 rtl/scan_code_fifo.sv | 60 ++++++
 rtl/editor_input_scheduler.sv | 149 ++++++++++++++
 tb/tb_editor_input_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/editor_pkg.sv
// editor_pkg: constants and types shared by the editor input scheduler.
//   - PS/2 set-2 scan-code constants (prefix bytes, arrow keys, backspace)
//   - scan parser state type
//   - arbiter command-select enum
package editor_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_EXT,
    PS_BRK,
    PS_EXTBRK
  } parse_state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_SAVE,
    CMD_PREV,
    CMD_NEXT,
    CMD_KEY
  } cmd_sel_e;

endpackage

// File: rtl/scan_code_fifo.sv
// scan_code_fifo: synchronous 8-bit FIFO holding parsed make codes.
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write request and data
//   pop, dout     : read request and head data (dout is the current head)
//   full, empty   : status
//   level         : number of stored entries
// A push while full is accepted when a pop happens in the same cycle.
module scan_code_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic push_ok, pop_ok;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign dout  = mem_q[rd_q];
  assign level = level_q;

  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
    level_d = level_q;
    if (push_ok && !pop_ok) level_d = level_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; only slots behind a valid pointer are ever read out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/editor_input_scheduler.sv
// editor_input_scheduler: front end of the sentence editor.
//   clk, reset            : clock, asynchronous active-high reset
//   enable                : issue permission (parsing/capture always run)
//   scan_byte, scan_valid : PS/2 receiver byte stream
//   btn_prev/next/save/load : debounced button levels
//   keyboard              : make code for one cycle, else 8'h00
//   prevWord/nextWord/save/load : one-cycle command pulses
//   fifo_level            : queued key codes
//   overflow              : sticky key-drop flag
module editor_input_scheduler
  import editor_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 0,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    scan_byte,
  input  logic          scan_valid,
  input  logic          btn_prev,
  input  logic          btn_next,
  input  logic          btn_save,
  input  logic          btn_load,
  output logic [7:0]    keyboard,
  output logic          prevWord,
  output logic          nextWord,
  output logic          save,
  output logic          load,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  parse_state_e ps_q, ps_d;
  cmd_sel_e     sel;
  logic [7:0]   held_q, held_d;
  logic [3:0]   btn_now, btn_hist_q, rise, pend_q, pend_d, eff, win;
  logic [GW-1:0] gap_q, gap_d;
  logic         ovf_q, ovf_d;
  logic [7:0]   kb_q, kb_d;
  logic [3:0]   cmd_q, cmd_d;
  logic         push, pop, is_make;
  logic         fifo_full, fifo_empty;
  logic [7:0]   fifo_dout;

  // Button vector order: [3]=load [2]=save [1]=prev [0]=next (priority high to low).
  assign btn_now = {btn_load, btn_save, btn_prev, btn_next};
  assign rise    = btn_now & ~btn_hist_q;
  // A rise is eligible in the same cycle it is seen, giving t+1 pulse latency.
  assign eff     = pend_q | rise;

  always_comb begin
    sel = CMD_NONE;
    if (enable && gap_q == '0) begin
      if (eff[3])           sel = CMD_LOAD;
      else if (eff[2])      sel = CMD_SAVE;
      else if (eff[1])      sel = CMD_PREV;
      else if (eff[0])      sel = CMD_NEXT;
      else if (!fifo_empty) sel = CMD_KEY;
    end
  end

  always_comb begin
    win    = {sel == CMD_LOAD, sel == CMD_SAVE, sel == CMD_PREV, sel == CMD_NEXT};
    pop    = (sel == CMD_KEY);
    // A rise that itself won the slot is consumed; a rise landing on a flag that
    // was already pending and just got cleared re-arms it.
    pend_d = (pend_q & ~win) | (rise & ~(win & ~pend_q));
    if (sel != CMD_NONE)  gap_d = GW'(GAP);
    else if (gap_q != '0) gap_d = gap_q - GW'(1);
    else                  gap_d = gap_q;
    kb_d  = pop ? fifo_dout : 8'h00;
    cmd_d = win;
  end

  always_comb begin
    ps_d    = ps_q;
    held_d  = held_q;
    is_make = 1'b0;
    if (scan_valid) begin
      case (ps_q)
        PS_IDLE: begin
          if (scan_byte == SC_BREAK)    ps_d = PS_BRK;
          else if (scan_byte == SC_EXT) ps_d = PS_EXT;
          else                          is_make = 1'b1;
        end
        PS_EXT: begin
          if (scan_byte == SC_BREAK) ps_d = PS_EXTBRK;
          else begin
            is_make = 1'b1;
            ps_d    = PS_IDLE;
          end
        end
        default: begin
          if (scan_byte == held_q) held_d = 8'h00;
          ps_d = PS_IDLE;
        end
      endcase
    end
    push = is_make && (scan_byte != held_q);
    if (push) held_d = scan_byte;
    ovf_d = ovf_q | (push && fifo_full && !pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q       <= PS_IDLE;
      held_q     <= 8'h00;
      btn_hist_q <= '0;
      pend_q     <= '0;
      gap_q      <= '0;
      ovf_q      <= 1'b0;
      kb_q       <= 8'h00;
      cmd_q      <= '0;
    end else begin
      ps_q       <= ps_d;
      held_q     <= held_d;
      btn_hist_q <= btn_now;
      pend_q     <= pend_d;
      gap_q      <= gap_d;
      ovf_q      <= ovf_d;
      kb_q       <= kb_d;
      cmd_q      <= cmd_d;
    end
  end

  scan_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .din   (scan_byte),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign keyboard = kb_q;
  assign load     = cmd_q[3];
  assign save     = cmd_q[2];
  assign prevWord = cmd_q[1];
  assign nextWord = cmd_q[0];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_editor_input_scheduler.sv
module tb_editor_input_scheduler;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, scan_valid = 1'b0;
  logic [7:0] scan_byte = 8'h00;
  logic btn_prev = 1'b0, btn_next = 1'b0, btn_save = 1'b0, btn_load = 1'b0;

  logic [7:0] kb0, kb1;
  logic prev0, next0, save0, load0, ovf0;
  logic prev1, next1, save1, load1, ovf1;
  logic [2:0] lvl0, lvl1;

  editor_input_scheduler #(.FIFO_DEPTH(4), .GAP(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .scan_byte(scan_byte), .scan_valid(scan_valid),
    .btn_prev(btn_prev), .btn_next(btn_next), .btn_save(btn_save), .btn_load(btn_load),
    .keyboard(kb0), .prevWord(prev0), .nextWord(next0), .save(save0), .load(load0),
    .fifo_level(lvl0), .overflow(ovf0)
  );

  editor_input_scheduler #(.FIFO_DEPTH(4), .GAP(2)) dut_gap (
    .clk(clk), .reset(reset), .enable(enable), .scan_byte(scan_byte), .scan_valid(scan_valid),
    .btn_prev(btn_prev), .btn_next(btn_next), .btn_save(btn_save), .btn_load(btn_load),
    .keyboard(kb1), .prevWord(prev1), .nextWord(next1), .save(save1), .load(load1),
    .fifo_level(lvl1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model of dut (GAP=0, depth 4) ----------------
  localparam int M_DEPTH = 4;
  logic [7:0] q_m[$];
  logic [7:0] held_m = 8'h00;
  int         mode_m = 0;              // 0 idle, 1 after E0, 2 expecting break code
  logic [3:0] pend_m = '0, hist_m = '0;
  int         gap_m = 0;
  logic       ovf_m = 1'b0;
  logic [7:0] e_kb = 8'h00;
  logic [3:0] e_cmd = '0;              // {load, save, prev, next}
  logic [2:0] e_lvl = '0;
  logic [3:0] m_b, m_rise, m_eff;
  int         m_iss;
  logic       m_make, m_did;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q_m.delete();
      held_m = 8'h00; mode_m = 0; pend_m = '0; hist_m = '0; gap_m = 0; ovf_m = 1'b0;
      e_kb = 8'h00; e_cmd = '0; e_lvl = '0;
    end else begin
      e_kb = 8'h00; e_cmd = '0; m_did = 1'b0;
      m_b    = {btn_load, btn_save, btn_prev, btn_next};
      m_rise = m_b & ~hist_m;
      hist_m = m_b;
      m_eff  = pend_m | m_rise;
      m_iss  = -1;
      if (enable && gap_m == 0) begin
        for (int i = 3; i >= 0; i--) if (m_eff[i] && m_iss < 0) m_iss = i;
        if (m_iss >= 0) begin
          e_cmd[m_iss] = 1'b1; m_did = 1'b1;
        end else if (q_m.size() > 0) begin
          e_kb = q_m.pop_front(); m_did = 1'b1;
        end
      end
      for (int i = 0; i < 4; i++)
        if (m_iss == i) pend_m[i] = pend_m[i] & m_rise[i];
        else            pend_m[i] = pend_m[i] | m_rise[i];
      if (m_did) gap_m = 0;
      else if (gap_m > 0) gap_m--;
      m_make = 1'b0;
      if (scan_valid) begin
        if (mode_m == 2) begin
          if (scan_byte == held_m) held_m = 8'h00;
          mode_m = 0;
        end else if (scan_byte == 8'hF0) mode_m = 2;
        else if (scan_byte == 8'hE0 && mode_m == 0) mode_m = 1;
        else begin
          m_make = 1'b1; mode_m = 0;
        end
      end
      if (m_make && scan_byte != held_m) begin
        if (q_m.size() < M_DEPTH) q_m.push_back(scan_byte);
        else ovf_m = 1'b1;
        held_m = scan_byte;
      end
      e_lvl = 3'(q_m.size());
    end
  end

  always @(negedge clk)
    chk("outputs{kb,ld,sv,pv,nx,lvl,ovf}", {kb0, load0, save0, prev0, next0, lvl0, ovf0},
        {e_kb, e_cmd, e_lvl, ovf_m});

  // ---------------- event log of dut for hand-computed checks ----------------
  typedef struct {
    int         c;
    logic [7:0] kb;
    logic [3:0] cmd;
  } ev_t;
  ev_t log_q[$];

  always @(negedge clk)
    if (kb0 != 8'h00 || {load0, save0, prev0, next0} != 4'b0000)
      log_q.push_back('{c: cyc, kb: kb0, cmd: {load0, save0, prev0, next0}});

  task automatic send(input logic [7:0] b);
    scan_byte = b; scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  int c0, npv;
  logic [7:0] codes [5];
  logic [1:0] gap_exp [6];

  initial begin
    codes   = '{8'h1C, 8'h24, 8'h43, 8'h44, 8'h3C};
    gap_exp = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};   // {save, prev} at +1..+6

    idle(2);
    chk("reset_keyboard", kb0, 8'h00);
    chk("reset_level", lvl0, 3'd0);
    chk("reset_overflow", ovf0, 1'b0);
    #1 reset = 1'b0; enable = 1'b1;
    @(negedge clk);

    // make / break pair issues exactly once, break clears held
    log_q.delete();
    send(8'h1C); chk("t1_level_after_push", lvl0, 3'd1);
    send(8'hF0); chk("t1_keyboard", kb0, 8'h1C); chk("t1_level_after_pop", lvl0, 3'd0);
    send(8'h1C); chk("t1_keyboard_cleared", kb0, 8'h00);
    idle(3);
    chk("t1_issue_count", log_q.size(), 1);
    send(8'h1C); idle(3);
    chk("t1_held_cleared_reissue", log_q.size(), 2);
    send(8'hF0); send(8'h1C); idle(2);

    // extended typematic: one 74 issued
    log_q.delete();
    send(8'hE0); send(8'h74); send(8'h74); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h74);
    idle(3);
    chk("t2_issue_count", log_q.size(), 1);
    chk("t2_code", log_q.size() > 0 ? log_q[0].kb : 8'hXX, 8'h74);

    // priority: load, next, then queued key
    enable = 1'b0;
    send(8'h2C); idle(1);
    log_q.delete();
    c0 = cyc; btn_load = 1'b1; btn_next = 1'b1; enable = 1'b1;
    idle(5);
    chk("t3_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t3_load_cycle", log_q[0].c, c0 + 1); chk("t3_load_cmd", log_q[0].cmd, 4'b1000);
      chk("t3_next_cycle", log_q[1].c, c0 + 2); chk("t3_next_cmd", log_q[1].cmd, 4'b0001);
      chk("t3_key_cycle", log_q[2].c, c0 + 3);  chk("t3_key_code", log_q[2].kb, 8'h2C);
    end
    btn_load = 1'b0; btn_next = 1'b0;
    send(8'hF0); send(8'h2C); idle(2);

    // overflow while disabled, then drain on consecutive cycles
    enable = 1'b0; log_q.delete();
    for (int i = 0; i < 5; i++) begin
      send(codes[i]); send(8'hF0); send(codes[i]);
    end
    chk("t4_level_full", lvl0, 3'd4);
    chk("t4_overflow", ovf0, 1'b1);
    c0 = cyc; enable = 1'b1;
    idle(7);
    chk("t4_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < log_q.size()) begin
        chk("t4_code", log_q[i].kb, codes[i]);
        chk("t4_cycle", log_q[i].c, c0 + 1 + i);
      end
    chk("t4_overflow_sticky", ovf0, 1'b1);

    // GAP=2 instance: save at +1, prev at +4
    pulse_reset();
    chk("t5_overflow_reset", ovf0, 1'b0);
    btn_prev = 1'b1; btn_save = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_gap_save_prev", {save1, prev1}, gap_exp[k]);
    end
    btn_prev = 1'b0; btn_save = 1'b0; idle(2);

    // merge while pending, then re-arm on the issue cycle
    enable = 1'b0; log_q.delete();
    btn_next = 1'b1; idle(1); btn_next = 1'b0; idle(1); btn_next = 1'b1; idle(1);
    btn_prev = 1'b1; idle(1); btn_prev = 1'b0; idle(1);
    btn_prev = 1'b1; enable = 1'b1; idle(6);
    npv = 0;
    foreach (log_q[i]) if (log_q[i].cmd == 4'b0010) npv++;
    chk("t7_prev_rearm_count", npv, 2);
    chk("t7_next_merged", log_q.size(), 3);
    btn_prev = 1'b0; btn_next = 1'b0; idle(2);

    // full FIFO: push and pop in the same cycle both complete
    enable = 1'b0; log_q.delete();
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    chk("t8_full", lvl0, 3'd4);
    enable = 1'b1; send(8'h2C);
    chk("t8_level_unchanged", lvl0, 3'd4);
    chk("t8_no_overflow", ovf0, 1'b0);
    idle(6);
    chk("t8_count", log_q.size(), 5);
    if (log_q.size() == 5) chk("t8_last", log_q[4].kb, 8'h2C);

    // reset after E0: next byte parsed from IDLE
    send(8'hE0);
    pulse_reset();
    log_q.delete();
    send(8'h6B); idle(3);
    chk("t6_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("t6_code", log_q[0].kb, 8'h6B);
    chk("t6_overflow", ovf0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
